branch_target_predictor: RTL

//  IF-stage branch predictor + EX-stage resolver for the 5-stage RV32 pipeline. Direct-mapped

---
 rtl/branch_target_predictor_if.sv | 44 ++++
 rtl/branch_target_predictor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor_if.sv
// branch_target_predictor_if
//   Bundles the fetch-side lookup and execute-side resolve signals of the
//   branch target predictor.
//   master : pipeline side (drives PCF and the EX-stage branch information)
//   slave  : predictor side (drives predictions, MispredE and RedirectPCE)
//   Optional macro BTB_PERF_CNT_EN adds the BrCountE/MissCountE counters.
interface branch_target_predictor_if;
    // fetch side
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    // execute side
    logic        ValidE;
    logic [2:0]  BranchTypeE;
    logic [31:0] PCE;
    logic        BranchE;
    logic [31:0] BrTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredE;
    logic [31:0] RedirectPCE;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] BrCountE;
    logic [31:0] MissCountE;

    modport master (
        output PCF, ValidE, BranchTypeE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE,
        input  PredTakenF, PredTargetF, MispredE, RedirectPCE, BrCountE, MissCountE
    );
    modport slave (
        input  PCF, ValidE, BranchTypeE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE,
        output PredTakenF, PredTargetF, MispredE, RedirectPCE, BrCountE, MissCountE
    );
`else
    modport master (
        output PCF, ValidE, BranchTypeE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE,
        input  PredTakenF, PredTargetF, MispredE, RedirectPCE
    );
    modport slave (
        input  PCF, ValidE, BranchTypeE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE,
        output PredTakenF, PredTargetF, MispredE, RedirectPCE
    );
`endif
endinterface

// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   IF-stage direct-mapped branch target predictor with EX-stage resolve and
//   training for a 5-stage RV32 pipeline. Each entry holds valid, tag, target
//   and a 2-bit saturating counter. Lookup is combinational from PCF; training
//   writes at the rising clock edge from the EX-stage branch outcome.
// Ports
//   clk : pipeline clock, all state on the rising edge
//   rst : asynchronous active-high reset (clears the table)
//   bp  : branch_target_predictor_if.slave
//         in : PCF, ValidE, BranchTypeE, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE
//         out: PredTakenF, PredTargetF, MispredE, RedirectPCE
//         (BrCountE, MissCountE when BTB_PERF_CNT_EN is defined)
// Parameters
//   IDX_W : index width, ENTRIES = 2**IDX_W, index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2]
// Configuration
//   BTB_PERF_CNT_EN : adds saturating branch and misprediction counters.
module branch_target_predictor #(
    parameter int IDX_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    branch_target_predictor_if.slave  bp
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    // Branch type encoding of the pipeline decoder (NOBRANCH is zero).
    localparam logic [2:0] BR_NOBRANCH = 3'd0;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    // ---------------------------------------------------------------- fetch
    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;

    assign idx_f = bp.PCF[IDX_W+1:2];
    assign tag_f = bp.PCF[31:IDX_W+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign bp.PredTakenF  = hit_f && ctr_q[idx_f][1];
    assign bp.PredTargetF = hit_f ? tgt_q[idx_f] : bp.PCF + 32'd4;

    // -------------------------------------------------------------- execute
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;
    logic             is_br;
    logic             mispred;
    logic [31:0]      redirect_pc;

    assign idx_e = bp.PCE[IDX_W+1:2];
    assign tag_e = bp.PCE[31:IDX_W+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign is_br = bp.BranchTypeE != BR_NOBRANCH;

    always_comb begin
        mispred     = 1'b0;
        redirect_pc = 32'd0;
        if (bp.ValidE) begin
            // A taken branch must also have been fetched from the right target.
            if (is_br) begin
                mispred = (bp.BranchE != bp.PredTakenE) ||
                          (bp.BranchE && (bp.PredTargetE != bp.BrTargetE));
            end else begin
                mispred = bp.PredTakenE;
            end
            redirect_pc = (is_br && bp.BranchE) ? bp.BrTargetE : bp.PCE + 32'd4;
        end
    end

    assign bp.MispredE    = mispred;
    assign bp.RedirectPCE = redirect_pc;

    // ------------------------------------------------------- table training
    logic             upd_en;
    logic             valid_d;
    logic [TAG_W-1:0] tag_d;
    logic [31:0]      tgt_d;
    logic [1:0]       ctr_d;

    always_comb begin
        upd_en  = 1'b0;
        valid_d = valid_q[idx_e];
        tag_d   = tag_q[idx_e];
        tgt_d   = tgt_q[idx_e];
        ctr_d   = ctr_q[idx_e];
        if (bp.ValidE) begin
            if (is_br && hit_e) begin
                upd_en = 1'b1;
                if (bp.BranchE) begin
                    if (ctr_q[idx_e] != 2'b11) ctr_d = ctr_q[idx_e] + 2'b01;
                    tgt_d = bp.BrTargetE;
                end else if (ctr_q[idx_e] != 2'b00) begin
                    ctr_d = ctr_q[idx_e] - 2'b01;
                end
            end else if (is_br && bp.BranchE) begin
                // Only taken branches allocate; they start weakly taken.
                upd_en  = 1'b1;
                valid_d = 1'b1;
                tag_d   = tag_e;
                tgt_d   = bp.BrTargetE;
                ctr_d   = 2'b10;
            end else if (!is_br && bp.PredTakenE && hit_e) begin
                // A non-branch hit the table and was predicted taken: drop the alias.
                upd_en  = 1'b1;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= 32'd0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_en) begin
            valid_q[idx_e] <= valid_d;
            tag_q[idx_e]   <= tag_d;
            tgt_q[idx_e]   <= tgt_d;
            ctr_q[idx_e]   <= ctr_d;
        end
    end

`ifdef BTB_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] br_cnt_d;
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bp.ValidE && is_br && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d = br_cnt_q + 32'd1;
        if (mispred && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q   <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bp.BrCountE   = br_cnt_q;
    assign bp.MissCountE = miss_cnt_q;
`endif

    // Byte-offset bits of word-aligned PCs carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.PCF[1:0], bp.PCE[1:0]};

endmodule
